recb11_detect: RTL and testbench

//   Producer side of the bus-off recovery count. Watches sampled bus bits at each

---
 rtl/recb11_detect.sv | 112 +++++++++++
 tb/tb_recb11_detect.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/recb11_detect.sv
// recb11_detect
//   Bus-off recovery sequence detector. Counts consecutive recessive bits at
//   each sample point and emits a one-clock elevrecb pulse for every
//   NUM_RECB consecutive recessive bits seen while recovery is enabled.
//   Also reports bus_idle once NUM_RECB recessive bits have been seen since
//   the last dominant bit, whether or not recovery is enabled.
//
// Ports
//   clock     in   1      system clock, rising edge
//   reset     in   1      synchronous, active-high reset
//   enable    in   1      bus-off recovery active; gates counting and elevrecb
//   sample    in   1      one-clock strobe at the bit sample point
//   rxbit     in   1      sampled bus value (1 = recessive, 0 = dominant)
//   elevrecb  out  1      one-clock pulse per completed recessive sequence
//   bus_idle  out  1      level: >= NUM_RECB recessive bits since last dominant
//   recb_cnt  out  CNT_W  current sequence count, 0..NUM_RECB-1
//
// State  | Meaning
// OFF    | recovery disabled, sequence count held at 0
// SEEK   | counting consecutive recessive samples
// HIT    | one cycle, elevrecb asserted; a sample here starts the next sequence
module recb11_detect #(
  parameter int NUM_RECB = 11,
  parameter int CNT_W    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sample,
  input  logic             rxbit,
  output logic             elevrecb,
  output logic             bus_idle,
  output logic [CNT_W-1:0] recb_cnt
);

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    SEEK = 2'd1,
    HIT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_RECB - 1);
  localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(NUM_RECB);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] seq_cnt;
  logic [CNT_W-1:0] seq_next;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] idle_next;
  logic             recessive;
  logic             dominant;
  logic             seq_done;

  assign recessive = sample & rxbit;
  assign dominant  = sample & ~rxbit;
  // A sample only counts toward a sequence while enable is high in that cycle.
  assign seq_done  = enable & recessive & (seq_cnt == LAST_BIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= OFF;
      seq_cnt  <= '0;
      idle_cnt <= '0;
    end else begin
      state    <= state_next;
      seq_cnt  <= seq_next;
      idle_cnt <= idle_next;
    end
  end

  always_comb begin
    state_next = state;
    seq_next   = seq_cnt;
    idle_next  = idle_cnt;

    // Idle tracking ignores enable entirely.
    if (dominant) begin
      idle_next = '0;
    end else if (recessive && (idle_cnt != IDLE_MAX)) begin
      idle_next = idle_cnt + 1'b1;
    end

    if (!enable) begin
      // HIT already drives elevrecb this cycle, so dropping to OFF here
      // never swallows a pending pulse.
      seq_next   = '0;
      state_next = OFF;
    end else begin
      if (dominant || seq_done) begin
        seq_next = '0;
      end else if (recessive) begin
        seq_next = seq_cnt + 1'b1;
      end

      case (state)
        OFF:     state_next = SEEK;
        SEEK:    state_next = seq_done ? HIT : SEEK;
        HIT:     state_next = SEEK;
        default: state_next = OFF;
      endcase
      // Count restarts at 0 after each hit, so no hit can occur from OFF or HIT.
    end
  end

  always_comb begin
    elevrecb = (state == HIT);
    bus_idle = (idle_cnt == IDLE_MAX);
    recb_cnt = seq_cnt;
  end

endmodule

// File: tb/tb_recb11_detect.sv
module tb_recb11_detect;

  localparam int N = 11;
  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic         sample = 1'b0;
  logic         rxbit = 1'b0;
  logic         elevrecb;
  logic         bus_idle;
  logic [W-1:0] recb_cnt;

  recb11_detect #(.NUM_RECB(N), .CNT_W(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .sample   (sample),
    .rxbit    (rxbit),
    .elevrecb (elevrecb),
    .bus_idle (bus_idle),
    .recb_cnt (recb_cnt)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: length of the current run of enabled recessive bits,
  // and length of the recessive run since the last dominant bit.
  int run = 0;
  int idle_run = 0;
  int exp_pulse = 0;
  int exp_idle = 0;
  int exp_cnt = 0;
  int cycle = 0;

  always @(posedge clock) begin
    cycle++;
    if (reset) begin
      run = 0; idle_run = 0; exp_pulse = 0;
    end else begin
      exp_pulse = 0;
      if (sample) idle_run = rxbit ? idle_run + 1 : 0;
      if (!enable) run = 0;
      else if (sample) begin
        if (!rxbit) run = 0;
        else begin
          run = run + 1;
          if (run == N) begin
            exp_pulse = 1;
            run = 0;
          end
        end
      end
    end
    exp_idle = (idle_run >= N) ? 1 : 0;
    exp_cnt  = run;
  end

  logic check_en = 1'b0;
  int   pulse_cnt = 0;
  int   pulse_cyc[$];

  always @(negedge clock) begin
    if (check_en) begin
      chk("model_elevrecb", int'(elevrecb), exp_pulse);
      chk("model_bus_idle", int'(bus_idle), exp_idle);
      chk("model_recb_cnt", int'(recb_cnt), exp_cnt);
      if (elevrecb) begin
        pulse_cnt++;
        pulse_cyc.push_back(cycle);
      end
    end
  end

  task automatic step(input logic s, input logic r);
    sample = s;
    rxbit  = r;
    @(posedge clock);
    #1;
    sample = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic rec_spaced(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b1);
      wait_cyc(gap);
    end
  endtask

  int base;

  initial begin
    // 1: reset dominates sample/rxbit
    reset = 1'b1; sample = 1'b1; rxbit = 1'b1; enable = 1'b1;
    wait_cyc(2);
    chk("rst_elevrecb", int'(elevrecb), 0);
    chk("rst_bus_idle", int'(bus_idle), 0);
    chk("rst_recb_cnt", int'(recb_cnt), 0);
    sample = 1'b0; rxbit = 1'b0; enable = 1'b0;
    reset = 1'b0;
    check_en = 1'b1;
    wait_cyc(2);

    // 2: 11 recessive samples, 4 clocks apart
    enable = 1'b1;
    wait_cyc(2);
    base = pulse_cnt;
    rec_spaced(10, 3);
    chk("t2_cnt_after10", int'(recb_cnt), 10);
    chk("t2_no_early", pulse_cnt - base, 0);
    step(1'b1, 1'b1);
    chk("t2_pulse", int'(elevrecb), 1);
    chk("t2_bus_idle", int'(bus_idle), 1);
    chk("t2_recb_cnt", int'(recb_cnt), 0);
    wait_cyc(1);
    chk("t2_width", int'(elevrecb), 0);
    wait_cyc(3);
    chk("t2_count", pulse_cnt - base, 1);

    // 3: 10 recessive, dominant, 11 recessive
    base = pulse_cnt;
    rec_spaced(10, 1);
    chk("t3_cnt_after10", int'(recb_cnt), 10);
    chk("t3_idle_held", int'(bus_idle), 1);
    step(1'b1, 1'b0);
    chk("t3_idle_drop", int'(bus_idle), 0);
    chk("t3_cnt_clr", int'(recb_cnt), 0);
    wait_cyc(1);
    rec_spaced(10, 1);
    chk("t3_no_pulse", pulse_cnt - base, 0);
    step(1'b1, 1'b1);
    chk("t3_pulse", int'(elevrecb), 1);
    wait_cyc(3);
    chk("t3_count", pulse_cnt - base, 1);

    // 4: 33 back-to-back recessive samples
    base = pulse_cnt;
    pulse_cyc.delete();
    sample = 1'b1; rxbit = 1'b1;
    repeat (33) begin
      @(posedge clock);
      #1;
    end
    sample = 1'b0;
    wait_cyc(3);
    chk("t4_count", pulse_cnt - base, 3);
    if (pulse_cyc.size() == 3) begin
      chk("t4_gap1", pulse_cyc[1] - pulse_cyc[0], 11);
      chk("t4_gap2", pulse_cyc[2] - pulse_cyc[1], 11);
    end else begin
      chk("t4_pulse_list", pulse_cyc.size(), 3);
    end

    // 5: disabled samples set bus_idle but never count
    enable = 1'b0;
    wait_cyc(1);
    step(1'b1, 1'b0);
    wait_cyc(1);
    base = pulse_cnt;
    rec_spaced(10, 1);
    chk("t5_idle_low", int'(bus_idle), 0);
    step(1'b1, 1'b1);
    chk("t5_idle_11", int'(bus_idle), 1);
    chk("t5_no_pulse", int'(elevrecb), 0);
    wait_cyc(1);
    rec_spaced(9, 1);
    chk("t5_off_cnt", int'(recb_cnt), 0);
    enable = 1'b1;
    wait_cyc(2);
    rec_spaced(10, 1);
    chk("t5_no_early", pulse_cnt - base, 0);
    step(1'b1, 1'b1);
    chk("t5_pulse", int'(elevrecb), 1);
    wait_cyc(3);
    chk("t5_count", pulse_cnt - base, 1);

    // 6: enable blip after 7 recessive samples restarts the count
    base = pulse_cnt;
    rec_spaced(7, 1);
    chk("t6_cnt7", int'(recb_cnt), 7);
    enable = 1'b0;
    wait_cyc(1);
    enable = 1'b1;
    wait_cyc(1);
    chk("t6_cnt_clr", int'(recb_cnt), 0);
    rec_spaced(10, 1);
    chk("t6_cnt10", int'(recb_cnt), 10);
    chk("t6_no_early", pulse_cnt - base, 0);
    step(1'b1, 1'b1);
    chk("t6_pulse", int'(elevrecb), 1);

    // Pending hit survives enable dropping during the pulse cycle
    wait_cyc(1);
    base = pulse_cnt;
    rec_spaced(10, 1);
    step(1'b1, 1'b1);
    enable = 1'b0;
    chk("hit_kept", int'(elevrecb), 1);
    wait_cyc(1);
    chk("hit_off", int'(elevrecb), 0);
    chk("hit_off_cnt", int'(recb_cnt), 0);
    wait_cyc(2);
    chk("hit_count", pulse_cnt - base, 1);

    // Mid-sequence reset with enable and samples active
    enable = 1'b1;
    wait_cyc(1);
    rec_spaced(5, 1);
    reset = 1'b1; sample = 1'b1; rxbit = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0; sample = 1'b0;
    chk("rst2_cnt", int'(recb_cnt), 0);
    chk("rst2_idle", int'(bus_idle), 0);
    wait_cyc(2);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
